// File: rtl/mips_cpu_pkg.sv
// Shared constants for the MIPS register writeback path: load size/sign encodings
// and the hard-wired zero register index.
package mips_cpu_pkg;

    localparam logic [2:0] LT_LW  = 3'd0;
    localparam logic [2:0] LT_LB  = 3'd1;
    localparam logic [2:0] LT_LBU = 3'd2;
    localparam logic [2:0] LT_LH  = 3'd3;
    localparam logic [2:0] LT_LHU = 3'd4;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/mips_cpu_reg_writeback_if.sv
// Execute/memory side of the register writeback block plus its register-file write port.
// The master modport is the pipeline driving results in; slave is the writeback block.
interface mips_cpu_reg_writeback_if #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5
);

    logic                  alu_valid;
    logic                  alu_ready;
    logic [REG_ADDR_W-1:0] alu_dest;
    logic [DATA_W-1:0]     alu_data;

    logic                  load_issue;
    logic                  load_ready;
    logic [REG_ADDR_W-1:0] load_dest;
    logic [2:0]            load_type;
    logic [1:0]            load_addr_low;

    logic                  mem_rdata_valid;
    logic [DATA_W-1:0]     mem_rdata;

    logic                  load_pending;
    logic [REG_ADDR_W-1:0] pending_dest;

    logic                  write_enable;
    logic [REG_ADDR_W-1:0] write_reg;
    logic [DATA_W-1:0]     write_data;

    modport master (
        output alu_valid, alu_dest, alu_data,
        output load_issue, load_dest, load_type, load_addr_low,
        output mem_rdata_valid, mem_rdata,
        input  alu_ready, load_ready, load_pending, pending_dest,
        input  write_enable, write_reg, write_data
    );

    modport slave (
        input  alu_valid, alu_dest, alu_data,
        input  load_issue, load_dest, load_type, load_addr_low,
        input  mem_rdata_valid, mem_rdata,
        output alu_ready, load_ready, load_pending, pending_dest,
        output write_enable, write_reg, write_data
    );

endinterface

// File: rtl/mips_cpu_load_formatter.sv
// Selects the addressed byte/half lane of a returned memory word (little-endian)
// and sign- or zero-extends it to a full register value.
module mips_cpu_load_formatter
    import mips_cpu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [2:0]        load_type,
    input  logic [1:0]        addr_low,
    input  logic [DATA_W-1:0] rdata,
    output logic [DATA_W-1:0] result
);

    function automatic logic [DATA_W-1:0] ext_byte(input logic [7:0] b, input logic sgn);
        logic signed [7:0] sb;
        sb = signed'(b);
        return sgn ? DATA_W'(sb) : {{(DATA_W-8){1'b0}}, b};
    endfunction

    function automatic logic [DATA_W-1:0] ext_half(input logic [15:0] h, input logic sgn);
        logic signed [15:0] sh;
        sh = signed'(h);
        return sgn ? DATA_W'(sh) : {{(DATA_W-16){1'b0}}, h};
    endfunction

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    // addr_low[0] is deliberately ignored for halfword lanes
    assign byte_lane = rdata[{addr_low, 3'b000} +: 8];
    assign half_lane = addr_low[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        result = rdata;
        case (load_type)
            LT_LB:   result = ext_byte(byte_lane, 1'b1);
            LT_LBU:  result = ext_byte(byte_lane, 1'b0);
            LT_LH:   result = ext_half(half_lane, 1'b1);
            LT_LHU:  result = ext_half(half_lane, 1'b0);
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/mips_cpu_reg_writeback.sv
// Single write-port master for the register file: merges ALU/link results with one
// outstanding load, applying load-first priority via a 1-entry skid and WAW cancel.
module mips_cpu_reg_writeback
    import mips_cpu_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5
) (
    input logic                      clk,
    input logic                      reset,
    mips_cpu_reg_writeback_if.slave  wb
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;

    logic [0:0]            state_p1;
    logic [REG_ADDR_W-1:0] pend_dest_p1;
    logic [2:0]            pend_type_p1;
    logic [1:0]            pend_addr_p1;
    logic                  cancel_p1;

    logic                  skid_vld_p1;
    logic [REG_ADDR_W-1:0] skid_dest_p1;
    logic [DATA_W-1:0]     skid_data_p1;

    logic                  we_p1;
    logic [REG_ADDR_W-1:0] wreg_p1;
    logic [DATA_W-1:0]     wdata_p1;

    logic                  alu_acc;
    logic                  ret;
    logic                  issue_acc;
    logic                  load_ready_c;
    logic [DATA_W-1:0]     load_result;

    logic                  wr_due;
    logic [REG_ADDR_W-1:0] wr_dest;
    logic [DATA_W-1:0]     wr_data;
    logic                  we_next;

    assign alu_acc      = wb.alu_valid & ~skid_vld_p1;
    assign ret          = wb.mem_rdata_valid & (state_p1 == ST_WAIT);
    assign load_ready_c = (state_p1 == ST_IDLE) | wb.mem_rdata_valid;
    assign issue_acc    = wb.load_issue & load_ready_c;

    mips_cpu_load_formatter #(.DATA_W(DATA_W)) u_fmt (
        .load_type (pend_type_p1),
        .addr_low  (pend_addr_p1),
        .rdata     (wb.mem_rdata),
        .result    (load_result)
    );

    // A returning load owns the write port; a cancelled return simply burns the slot.
    always_comb begin
        wr_due  = 1'b0;
        wr_dest = skid_dest_p1;
        wr_data = skid_data_p1;
        if (ret) begin
            wr_due  = ~cancel_p1;
            wr_dest = pend_dest_p1;
            wr_data = load_result;
        end else if (skid_vld_p1) begin
            wr_due  = 1'b1;
        end else if (alu_acc) begin
            wr_due  = 1'b1;
            wr_dest = wb.alu_dest;
            wr_data = wb.alu_data;
        end
    end

    assign we_next = wr_due & (wr_dest != REG_ADDR_W'(REG_ZERO));

    // Stage p1: control state, reset-cleared
    always_ff @(posedge clk) begin
        if (reset) begin
            state_p1     <= ST_IDLE;
            pend_dest_p1 <= '0;
            cancel_p1    <= 1'b0;
            skid_vld_p1  <= 1'b0;
            we_p1        <= 1'b0;
            wreg_p1      <= '0;
            wdata_p1     <= '0;
        end else begin
            if (issue_acc) begin
                state_p1     <= ST_WAIT;
                pend_dest_p1 <= wb.load_dest;
                cancel_p1    <= 1'b0;
            end else if (ret) begin
                state_p1     <= ST_IDLE;
                pend_dest_p1 <= '0;
                cancel_p1    <= 1'b0;
            end else if (state_p1 == ST_WAIT && alu_acc && wb.alu_dest == pend_dest_p1) begin
                cancel_p1    <= 1'b1;
            end

            if (ret && alu_acc) begin
                skid_vld_p1 <= 1'b1;
            end else if (!ret && skid_vld_p1) begin
                skid_vld_p1 <= 1'b0;
            end

            we_p1 <= we_next;
            if (we_next) begin
                wreg_p1  <= wr_dest;
                wdata_p1 <= wr_data;
            end
        end
    end

    // Stage p1: datapath captures, no reset needed
    always_ff @(posedge clk) begin
        if (issue_acc) begin
            pend_type_p1 <= wb.load_type;
            pend_addr_p1 <= wb.load_addr_low;
        end
        if (ret && alu_acc) begin
            skid_dest_p1 <= wb.alu_dest;
            skid_data_p1 <= wb.alu_data;
        end
    end

    assign wb.alu_ready    = ~skid_vld_p1;
    assign wb.load_ready   = load_ready_c;
    assign wb.load_pending = (state_p1 == ST_WAIT);
    assign wb.pending_dest = pend_dest_p1;
    assign wb.write_enable = we_p1;
    assign wb.write_reg    = wreg_p1;
    assign wb.write_data   = wdata_p1;

endmodule
